// File: rtl/egress_rr_scheduler.sv
// Round-robin egress scheduler: grants whole frames from N_PORTS FWFT frame queues
// onto a byte-wide GMII-style TX interface, with inter-frame gap, pause and oversize abort.
module egress_rr_scheduler #(
  parameter int N_PORTS    = 3,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_FRAME  = 1526
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_PORTS-1:0]     req,
  input  logic [8*N_PORTS-1:0]   rd_data,
  input  logic [N_PORTS-1:0]     rd_last,
  input  logic [N_PORTS-1:0]     rd_err,
  output logic [N_PORTS-1:0]     rd_en,
  input  logic                   pause_req,
  output logic                   tx_dv,
  output logic                   tx_er,
  output logic [7:0]             tx_data,
  output logic [2:0]             grant_id,
  output logic                   tx_busy,
  output logic [15:0]            frames_sent,
  output logic [15:0]            err_cnt
);

  localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int BW = $clog2(MAX_FRAME + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] IFG   = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ifg_cnt;
  logic [BW-1:0] byte_cnt;

  logic [7:0]    sel_data;
  logic          sel_last;
  logic          sel_err;
  logic [2:0]    winner;
  logic          found;
  logic          arb_point;
  logic          start;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_err  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_id == 3'(i)) begin
        sel_data = rd_data[8*i +: 8];
        sel_last = rd_last[i];
        sel_err  = rd_err[i];
      end
    end
  end

  always_comb begin
    rd_en = '0;
    if (state == SEND || state == DRAIN) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (grant_id == 3'(i)) rd_en[i] = 1'b1;
      end
    end
  end

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin : arb
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = grant_id;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = int'(grant_id) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

  assign arb_point = (state == IDLE) || (state == IFG && ifg_cnt == '0);
  assign start     = arb_point && !pause_req && found;
  assign tx_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_dv       <= 1'b0;
      tx_er       <= 1'b0;
      tx_data     <= '0;
      grant_id    <= 3'(N_PORTS - 1);
      frames_sent <= '0;
      err_cnt     <= '0;
      byte_cnt    <= '0;
      ifg_cnt     <= '0;
    end else begin
      tx_dv   <= 1'b0;
      tx_er   <= 1'b0;
      tx_data <= '0;
      case (state)
        SEND: begin
          tx_dv    <= 1'b1;
          tx_data  <= sel_data;
          tx_er    <= sel_err;
          byte_cnt <= byte_cnt + BW'(1);
          if (sel_last) begin
            state       <= IFG;
            ifg_cnt     <= IW'(IFG_CYCLES - 1);
            frames_sent <= frames_sent + 16'd1;
          end else if (byte_cnt == BW'(MAX_FRAME - 1)) begin
            // Oversize: flag the final forwarded byte, then silently pop the rest.
            tx_er   <= 1'b1;
            err_cnt <= err_cnt + 16'd1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (sel_last) begin
            state   <= IFG;
            ifg_cnt <= IW'(IFG_CYCLES - 1);
          end
        end
        IFG: begin
          if (ifg_cnt != '0) ifg_cnt <= ifg_cnt - IW'(1);
        end
        default: ;
      endcase
      if (start) begin
        grant_id <= winner;
        byte_cnt <= '0;
        state    <= SEND;
      end else if (arb_point) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_egress_rr_scheduler.sv
// Self-checking bench for egress_rr_scheduler: FWFT queue models feed the DUT and a
// frame-level round-robin model predicts order, bytes, gaps and counters.
module tb_egress_rr_scheduler;

  localparam int N    = 3;
  localparam int IFGC = 12;
  localparam int MAXF = 1526;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] rd_data = '0;
  logic [2:0]  rd_last = '0;
  logic [2:0]  rd_err = '0;
  logic [2:0]  rd_en;
  logic        pause_req = 1'b0;
  logic        tx_dv;
  logic        tx_er;
  logic [7:0]  tx_data;
  logic [2:0]  grant_id;
  logic        tx_busy;
  logic [15:0] frames_sent;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  egress_rr_scheduler #(.N_PORTS(N), .IFG_CYCLES(IFGC), .MAX_FRAME(MAXF)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rd_data(rd_data), .rd_last(rd_last),
    .rd_err(rd_err), .rd_en(rd_en), .pause_req(pause_req), .tx_dv(tx_dv),
    .tx_er(tx_er), .tx_data(tx_data), .grant_id(grant_id), .tx_busy(tx_busy),
    .frames_sent(frames_sent), .err_cnt(err_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Queue entries are {err, last, data}; the model store keeps {err, data} per frame.
  logic [9:0] q[N][$];
  int         qframes[N];
  logic [8:0] store[$];
  int         mf_start[N][$];
  int         mf_len[N][$];
  int         m_last = N - 1;
  int         m_fs = 0;
  int         m_ec = 0;

  logic [8:0] exp_bytes[$];
  int         exp_len[$], exp_port[$], exp_gap[$];
  logic [8:0] obs_bytes[$];
  int         obs_len[$], obs_port[$], obs_gap[$], obs_start[$];
  bit         in_frame = 1'b0;
  int         cur_len = 0, cur_gap = 0, cur_port = 0, cur_start = 0, idle_run = 0;
  logic [2:0] en_s = '0;

  typedef struct {
    int    len0, len1, len2;
    int    reps;
    string ord;
    int    fs;
    int    ec;
  } vec_t;

  task automatic check_output(input string name, input int act, input int want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic refresh_drive();
    for (int p = 0; p < N; p++) begin
      if (q[p].size() > 0) begin
        rd_data[8*p +: 8] = q[p][0][7:0];
        rd_last[p]        = q[p][0][8];
        rd_err[p]         = q[p][0][9];
      end else begin
        rd_data[8*p +: 8] = '0;
        rd_last[p]        = 1'b0;
        rd_err[p]         = 1'b0;
      end
      req[p] = (qframes[p] > 0);
    end
  endtask

  // Queue side: pop on the rd_en seen before the edge, then present the new head.
  always @(posedge clk) begin
    logic [9:0] tmp;
    cyc++;
    #1;
    for (int p = 0; p < N; p++) begin
      if (en_s[p]) begin
        if (q[p].size() == 0) check_output("pop_from_empty_queue", p, -1);
        else begin
          tmp = q[p].pop_front();
          if (tmp[8]) qframes[p]--;
        end
      end
    end
    refresh_drive();
  end

  always @(negedge clk) begin
    en_s = rst_n ? rd_en : '0;
    if (rst_n) begin
      check_output("rd_en_onehot", int'($countones(rd_en) <= 1), 1);
      if (!tx_dv) check_output("idle_er_data", int'({tx_er, tx_data}), 0);
    end
    if (tx_dv) begin
      if (!in_frame) begin
        in_frame  = 1'b1;
        cur_len   = 0;
        cur_gap   = idle_run;
        cur_port  = int'(grant_id);
        cur_start = cyc;
      end
      obs_bytes.push_back({tx_er, tx_data});
      cur_len++;
    end else begin
      if (in_frame) begin
        obs_len.push_back(cur_len);
        obs_gap.push_back(cur_gap);
        obs_port.push_back(cur_port);
        obs_start.push_back(cur_start);
        in_frame = 1'b0;
        idle_run = 0;
      end
      idle_run++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input int p, input int len, input bit errs);
    logic [7:0] d;
    bit e;
    mf_start[p].push_back(store.size());
    mf_len[p].push_back(len);
    for (int j = 0; j < len; j++) begin
      d = 8'($urandom);
      e = errs && ($urandom_range(0, 15) == 0);
      q[p].push_back({e, (j == len - 1), d});
      store.push_back({e, d});
    end
    qframes[p]++;
    refresh_drive();
  endtask

  task automatic clear_obs();
    obs_bytes.delete(); obs_len.delete(); obs_port.delete();
    obs_gap.delete(); obs_start.delete();
    exp_bytes.delete(); exp_len.delete(); exp_port.delete(); exp_gap.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pause_req = 1'b0;
    for (int p = 0; p < N; p++) begin
      q[p].delete(); qframes[p] = 0;
      mf_start[p].delete(); mf_len[p].delete();
    end
    store.delete();
    refresh_drive();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    clear_obs();
    in_frame = 1'b0;
    idle_run = 0;
    m_last = N - 1;
    m_fs = 0;
    m_ec = 0;
  endtask

  // Frame-level reference: serve backlog round-robin from the last grant; oversize
  // frames are cut at MAXF bytes with the cut byte flagged, and their unsent tail
  // stretches the following idle gap.
  task automatic build_expected();
    int g, pp, st, ln, n, prev_len, c;
    bit first, any;
    logic [8:0] b;
    g = m_last;
    first = 1'b1;
    prev_len = 0;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      pp = 0;
      for (int k = 1; k <= N; k++) begin
        c = (g + k) % N;
        if (!any && mf_len[c].size() > 0) begin any = 1'b1; pp = c; end
      end
      if (any) begin
        st = mf_start[pp].pop_front();
        ln = mf_len[pp].pop_front();
        n  = (ln > MAXF) ? MAXF : ln;
        for (int j = 0; j < n; j++) begin
          b = store[st + j];
          if (ln > MAXF && j == n - 1) b[8] = 1'b1;
          exp_bytes.push_back(b);
        end
        exp_len.push_back(n);
        exp_port.push_back(pp);
        exp_gap.push_back(first ? -1 : IFGC + ((prev_len > MAXF) ? prev_len - MAXF : 0));
        if (ln > MAXF) m_ec++; else m_fs++;
        first = 1'b0;
        prev_len = ln;
        g = pp;
      end
    end
    m_last = g;
    store.delete();
  endtask

  function automatic bit pending();
    bit r;
    r = tx_busy || in_frame;
    for (int p = 0; p < N; p++) if (q[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin tick(); n++; end
    check_output({tag, " drain_timeout"}, int'(pending()), 0);
  endtask

  task automatic wait_bytes(input string tag, input int nb, input int budget);
    int n;
    n = 0;
    while (!(in_frame && cur_len >= nb) && n < budget) begin tick(); n++; end
    check_output({tag, " byte_wait_timeout"}, int'(in_frame && cur_len >= nb), 1);
  endtask

  task automatic compare_frames(input string tag, input int push_cyc);
    int oi, ei, mm, nf;
    check_output({tag, " frame_count"}, obs_len.size(), exp_len.size());
    nf = (obs_len.size() < exp_len.size()) ? obs_len.size() : exp_len.size();
    oi = 0;
    ei = 0;
    for (int i = 0; i < nf; i++) begin
      check_output({tag, " port"}, obs_port[i], exp_port[i]);
      check_output({tag, " length"}, obs_len[i], exp_len[i]);
      if (exp_gap[i] >= 0) check_output({tag, " idle_gap"}, obs_gap[i], exp_gap[i]);
      mm = -1;
      for (int j = 0; j < obs_len[i] && j < exp_len[i]; j++)
        if (mm < 0 && obs_bytes[oi + j] !== exp_bytes[ei + j]) mm = j;
      check_output({tag, " first_bad_byte_index"}, mm, -1);
      oi += obs_len[i];
      ei += exp_len[i];
    end
    if (push_cyc >= 0 && obs_start.size() > 0)
      check_output({tag, " first_byte_latency"}, obs_start[0] - push_cyc, 2);
    check_output({tag, " frames_sent"}, int'(frames_sent), m_fs & 16'hFFFF);
    check_output({tag, " err_cnt"}, int'(err_cnt), m_ec & 16'hFFFF);
    clear_obs();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   pc, rc, lens[N], nf, len;
    bit   pushed;

    vecs[0] = '{0, 64, 0, 1, "1", 1, 0};
    vecs[1] = '{72, 72, 72, 2, "012012", 6, 0};
    vecs[2] = '{0, 0, 1600, 2, "22", 0, 2};
    vecs[3] = '{0, 0, 40, 3, "222", 3, 0};
    vecs[4] = '{1, 0, 5, 2, "0202", 4, 0};
    vecs[5] = '{1526, 1527, 0, 1, "01", 1, 1};

    apply_reset();
    check_output("reset tx_dv", int'(tx_dv), 0);
    check_output("reset grant_id", int'(grant_id), N - 1);
    check_output("reset frames_sent", int'(frames_sent), 0);
    check_output("reset err_cnt", int'(err_cnt), 0);
    check_output("reset tx_busy", int'(tx_busy), 0);

    for (int v = 0; v < 6; v++) begin
      apply_reset();
      lens[0] = vecs[v].len0;
      lens[1] = vecs[v].len1;
      lens[2] = vecs[v].len2;
      for (int r = 0; r < vecs[v].reps; r++)
        for (int p = 0; p < N; p++)
          if (lens[p] > 0) apply_stimulus(p, lens[p], 1'b1);
      pc = cyc;
      build_expected();
      wait_idle("vec", 8000);
      check_output("vec order_count", obs_port.size(), vecs[v].ord.len());
      for (int k = 0; k < vecs[v].ord.len() && k < obs_port.size(); k++)
        check_output("vec order", obs_port[k], int'(vecs[v].ord[k]) - 48);
      check_output("vec final_grant", int'(grant_id),
                   int'(vecs[v].ord[vecs[v].ord.len() - 1]) - 48);
      check_output("vec table_frames_sent", int'(frames_sent), vecs[v].fs);
      check_output("vec table_err_cnt", int'(err_cnt), vecs[v].ec);
      compare_frames("vec", pc);
    end

    // Pause lands mid-frame: frame completes, nothing starts until release.
    apply_reset();
    apply_stimulus(0, 100, 1'b0);
    apply_stimulus(1, 30, 1'b0);
    pc = cyc;
    build_expected();
    exp_gap[1] = -1;
    wait_bytes("pause", 20, 200);
    pause_req = 1'b1;
    rc = 0;
    while (tx_busy && rc < 500) begin tick(); rc++; end
    check_output("pause busy_clear", int'(tx_busy), 0);
    repeat (50) tick();
    check_output("pause frames_while_paused", obs_len.size(), 1);
    check_output("pause no_tx_while_paused", int'(tx_dv) + int'(in_frame), 0);
    check_output("pause rd_en_while_paused", int'(rd_en), 0);
    rc = cyc;
    pause_req = 1'b0;
    wait_idle("pause", 500);
    if (obs_start.size() > 1) check_output("pause release_latency", obs_start[1] - rc, 2);
    else check_output("pause second_frame_present", obs_start.size(), 2);
    compare_frames("pause", pc);

    // Reset mid-frame of port 1; afterwards port 0 must still win first.
    apply_reset();
    apply_stimulus(1, 100, 1'b0);
    wait_bytes("rstmid", 30, 200);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("rstmid tx_dv", int'(tx_dv), 0);
    check_output("rstmid tx_er", int'(tx_er), 0);
    check_output("rstmid tx_data", int'(tx_data), 0);
    check_output("rstmid rd_en", int'(rd_en), 0);
    check_output("rstmid grant_id", int'(grant_id), N - 1);
    apply_reset();
    apply_stimulus(0, 20, 1'b0);
    apply_stimulus(2, 20, 1'b0);
    pc = cyc;
    build_expected();
    wait_idle("rstmid", 500);
    if (obs_port.size() > 0) check_output("rstmid first_port", obs_port[0], 0);
    compare_frames("rstmid", pc);

    // Randomized backlogs against the frame-level model.
    apply_reset();
    for (int r = 0; r < 15; r++) begin
      pushed = 1'b0;
      for (int p = 0; p < N; p++) begin
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) begin
          len = ($urandom_range(0, 29) == 0) ? $urandom_range(1527, 1540) : $urandom_range(1, 48);
          apply_stimulus(p, len, 1'b1);
          pushed = 1'b1;
        end
      end
      pc = pushed ? cyc : -1;
      build_expected();
      wait_idle("rand", 20000);
      compare_frames("rand", pc);
      repeat ($urandom_range(0, 5)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
